// File: rtl/rpn_key_controller.sv
// rpn_key_controller
//   Turns numpad key codes into single-shot commands for an RPN stack.
//   One action per key press; the next press is accepted only after the key
//   has been idle for RELEASE_CYCLES consecutive cycles.
//
// Ports
//   clock     system clock, rising edge
//   reset     asynchronous, active-low reset
//   key       bit4 = pressed, bits3:0 = key id
//   hex_mode  0 = decimal entry, 1 = hex entry
//   top/next  top two stack elements
//   count     number of elements on the stack
//   write     one-cycle pulse: stack loads value into top
//   push      one-cycle pulse: stack pushes
//   pop       one-cycle pulse: stack pops (paired with write for binary ops)
//   value     new top value, held between writes
//   busy      multiply in progress
//   err       one-cycle pulse when a command is rejected
//   overflow  sticky arithmetic overflow flag
//
// state   | meaning
// IDLE    | waiting for a key press; decode and capture operands
// ISSUE   | registered command/err pulse is on the outputs
// MUL     | shift-add multiply, one multiplier bit per cycle
// RELEASE | waiting for RELEASE_CYCLES consecutive idle key cycles

module rpn_key_controller #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 32,
  parameter int CNT_W          = 6,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       key,
  input  logic             hex_mode,
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] next,
  input  logic [CNT_W-1:0] count,
  output logic             write,
  output logic             push,
  output logic             pop,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             err,
  output logic             overflow
);

  localparam int MC_W = $clog2(WIDTH);
  localparam int RC_W = $clog2(RELEASE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, MUL, RELEASE} state_t;
  typedef enum logic [2:0] {CMD_DIGIT, CMD_PUSH, CMD_ADD, CMD_SUB,
                            CMD_MUL, CMD_CLR, CMD_DROP} cmd_t;

  state_t           state_q, state_d;
  logic             write_q, write_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [RC_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;

  cmd_t             cmd;
  logic [3:0]       digit;
  logic [WIDTH+3:0] top_ext;
  logic [WIDTH+3:0] scaled;
  logic [WIDTH+3:0] digit_full;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    cmd   = CMD_DIGIT;
    digit = 4'd0;
    case (key[3:0])
      4'b0011: digit = 4'd0;
      4'b0000: digit = 4'd1;
      4'b0100: digit = 4'd2;
      4'b1000: digit = 4'd3;
      4'b0001: digit = 4'd4;
      4'b0101: digit = 4'd5;
      4'b1001: digit = 4'd6;
      4'b0010: digit = 4'd7;
      4'b0110: digit = 4'd8;
      4'b1010: digit = 4'd9;
      4'b1100: cmd = CMD_PUSH;
      4'b1101: cmd = CMD_ADD;
      4'b1110: cmd = CMD_SUB;
      4'b1111: cmd = CMD_MUL;
      4'b0111: cmd = CMD_CLR;
      4'b1011: cmd = CMD_DROP;
    endcase
  end

  // Digit entry is computed 4 bits wider so any bit above WIDTH flags overflow.
  assign top_ext    = {4'b0000, top};
  assign scaled     = hex_mode ? (top_ext << 4) : ((top_ext << 3) + (top_ext << 1));
  assign digit_full = scaled + {{WIDTH{1'b0}}, digit};
  assign add_full   = {1'b0, next} + {1'b0, top};
  assign sub_full   = {1'b0, next} - {1'b0, top};

  // One shift-add step: {hi,lo} holds partial product and remaining multiplier bits.
  assign addend   = lo_q[0] ? mcand_q : '0;
  assign step_sum = {1'b0, hi_q} + {1'b0, addend};
  assign step_hi  = step_sum[WIDTH:1];
  assign step_lo  = {step_sum[0], lo_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    write_d   = 1'b0;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    value_d   = value_q;
    rel_cnt_d = rel_cnt_q;
    mul_cnt_d = mul_cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;

    case (state_q)
      IDLE: begin
        if (key[4]) begin
          state_d = ISSUE;
          case (cmd)
            CMD_DIGIT: begin
              write_d = 1'b1;
              value_d = digit_full[WIDTH-1:0];
              if (|digit_full[WIDTH+3:WIDTH]) ovf_d = 1'b1;
            end
            CMD_PUSH: begin
              if (count == CNT_W'(DEPTH)) err_d  = 1'b1;
              else                        push_d = 1'b1;
            end
            CMD_ADD: begin
              if (count < CNT_W'(2)) err_d = 1'b1;
              else begin
                write_d = 1'b1;
                pop_d   = 1'b1;
                value_d = add_full[WIDTH-1:0];
                if (add_full[WIDTH]) ovf_d = 1'b1;
              end
            end
            CMD_SUB: begin
              if (count < CNT_W'(2)) err_d = 1'b1;
              else begin
                write_d = 1'b1;
                pop_d   = 1'b1;
                value_d = sub_full[WIDTH-1:0];
                if (sub_full[WIDTH]) ovf_d = 1'b1;
              end
            end
            CMD_MUL: begin
              if (count < CNT_W'(2)) err_d = 1'b1;
              else begin
                state_d   = MUL;
                busy_d    = 1'b1;
                mcand_d   = next;
                lo_d      = top;
                hi_d      = '0;
                mul_cnt_d = MC_W'(WIDTH - 1);
              end
            end
            CMD_CLR: begin
              write_d = 1'b1;
              value_d = '0;
              ovf_d   = 1'b0;
            end
            CMD_DROP: begin
              if (count == '0) err_d = 1'b1;
              else             pop_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        state_d   = RELEASE;
        rel_cnt_d = RC_W'(RELEASE_CYCLES);
      end
      MUL: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (mul_cnt_q == '0) begin
          state_d   = RELEASE;
          rel_cnt_d = RC_W'(RELEASE_CYCLES);
          busy_d    = 1'b0;
          write_d   = 1'b1;
          pop_d     = 1'b1;
          value_d   = step_lo;
          if (|step_hi) ovf_d = 1'b1;
        end else begin
          mul_cnt_d = mul_cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        if (key[4])                     rel_cnt_d = RC_W'(RELEASE_CYCLES);
        else if (rel_cnt_q <= RC_W'(1)) state_d   = IDLE;
        else                            rel_cnt_d = rel_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      value_q   <= '0;
      rel_cnt_q <= '0;
      mul_cnt_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      push_q    <= push_d;
      pop_q     <= pop_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      value_q   <= value_d;
      rel_cnt_q <= rel_cnt_d;
      mul_cnt_q <= mul_cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
    end
  end

  assign write    = write_q;
  assign push     = push_q;
  assign pop      = pop_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign value    = value_q;

endmodule
